router_fsm_nport: RTL and testbench
===================================

# router_fsm_nport

Parametrised ingress controller for the router's N-output datapath. It decodes the header address and sequences header, payload and parity loading into the selected output FIFO. It also handles FIFO-full stalls, soft resets and parity check hand-off. It replaces the fixed 3-port controller, and adds two behaviours: detection of out-of-range addresses, and a wait-for-empty watchdog that drops the packet instead of hanging.

## Interface
Parameters:
- NUM_PORTS, 3, number of output FIFOs (2..2**ADDR_W)
- ADDR_W, 2, width of header address field
- WAIT_TIMEOUT, 16, max cycles in WAIT_TILL_EMPTY before the packet is dropped; 0 disables the watchdog

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clock  in  1  rising-edge clock
  - reset  in  1  synchronous, active-high reset
- Inputs:
  - pkt_valid  in  1  source packet-valid
  - data_in  in  ADDR_W  header address bits (data[ADDR_W-1:0])
  - parity_done  in  1  parity byte captured by register block
  - low_packet_valid  in  1  pkt_valid fell while FIFO was full
  - fifo_full  in  1  full flag of currently selected FIFO
  - fifo_empty  in  NUM_PORTS  empty flag per FIFO
  - soft_reset  in  NUM_PORTS  per-FIFO read-timeout soft reset
- State-decode outputs:
  - detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  state decodes
  - write_enb_reg  out  1  FIFO write enable
  - busy  out  1  source must hold data
  - drop_state  out  1  packet being discarded
- Address and error outputs:
  - dest_addr  out  ADDR_W  latched destination
  - addr_err  out  1  one-cycle pulse, invalid address
  - timeout_err  out  1  one-cycle pulse, watchdog expiry

## Operation
- States:
  - DECODE_ADDRESS (DA)
  - WAIT_TILL_EMPTY (WTE)
  - LOAD_FIRST_DATA (LFD)
  - LOAD_DATA (LD)
  - LOAD_PARITY (LP)
  - FIFO_FULL_STATE (FFS)
  - LOAD_AFTER_FULL (LAF)
  - CHECK_PARITY_ERROR (CPE)
  - DROP_PACKET (DROP)
- dest_addr loads data_in every cycle in DA while pkt_valid=1 and holds elsewhere.
- Transitions:
  - DA:
    - pkt_valid && data_in>=NUM_PORTS -> DROP, addr_err=1 next cycle.
    - pkt_valid && fifo_empty[data_in] -> LFD.
    - pkt_valid && !fifo_empty[data_in] -> WTE.
    - Otherwise stay.
  - WTE:
    - fifo_empty[dest_addr] -> LFD. This check has priority over the watchdog.
    - Else if WAIT_TIMEOUT!=0 && wait_cnt==WAIT_TIMEOUT-1 -> DROP, timeout_err=1 next cycle.
    - Else stay.
  - LFD -> LD unconditionally.
  - LD:
    - fifo_full -> FFS.
    - Else !pkt_valid -> LP.
    - Else stay.
  - FFS: !fifo_full -> LAF, else stay.
  - LAF:
    - parity_done -> DA.
    - Else low_packet_valid -> LP.
    - Else -> LD.
  - LP -> CPE.
  - CPE: fifo_full -> FFS, else -> DA.
  - DROP: !pkt_valid -> DA. The parity byte is discarded on that cycle. Else stay.
  - Any unused encoding -> DA.
- Soft reset: soft_reset[dest_addr]=1 in any state other than DA or DROP forces DA next cycle. It overrides every transition. soft_reset bits of non-selected ports are ignored.
- Output decodes (Moore, purely from state):
  - busy=1 in LFD, LP, FFS, LAF, WTE, CPE. busy=0 in DA, LD, DROP.
  - write_enb_reg=1 in LD, LAF, LP.
  - detect_add=DA, lfd_state=LFD, ld_state=LD, laf_state=LAF, full_state=FFS, rst_int_reg=CPE, drop_state=DROP.
- Watchdog:
  - wait_cnt width is $clog2(WAIT_TIMEOUT+1).
  - It clears whenever state!=WTE and increments each cycle in WTE.
  - Result: at most WAIT_TIMEOUT cycles are spent in WTE.

## Timing
- Reset (synchronous, one edge):
  - state=DA, dest_addr=0, wait_cnt=0.
  - detect_add=1; all other outputs 0, including addr_err and timeout_err.
  - Reset wins over soft_reset and all inputs.
- Header accepted in DA at edge t: state changes at t. Outputs reflect the new state in cycle t+1.
- Fastest packet: DA -> LFD -> LD, so the first payload write occurs 2 cycles after the header edge.
- Parity path: parity byte arrives with pkt_valid=0 in LD. The sequence is LD -> LP -> CPE -> DA, so rst_int_reg is high exactly 1 cycle.
- Error pulses:
  - addr_err and timeout_err are registered, high for exactly the first cycle in DROP.
  - They never assert together.
- Full stall: fifo_full in LD gives FFS on the next edge. write_enb_reg is 0 throughout FFS.
- Simultaneous events:
  - fifo_empty[dest] rising on the watchdog's final WTE cycle -> LFD, no timeout_err.
  - soft_reset[dest] in the same cycle as a transition -> DA.

## Test plan
- Header addr=1, fifo_empty=3'b111, 3 payload bytes then parity -> state sequence DA, LFD, LD×3, LP, CPE, DA. write_enb_reg is high 4 cycles and busy is 0 during LD.
- Header addr=2, fifo_empty[2]=0 for 5 cycles then 1, WAIT_TIMEOUT=16 -> 5 cycles in WTE, then LFD, no timeout_err.
- Header addr=0, fifo_empty[0] held 0, WAIT_TIMEOUT=16 -> exactly 16 cycles in WTE, then DROP with one-cycle timeout_err. Returns to DA the cycle after pkt_valid falls.
- NUM_PORTS=3, header addr=3 -> DROP, addr_err pulse, busy=0. Bytes are consumed until pkt_valid=0, then DA with write_enb_reg never asserted.
- fifo_full asserted in the 2nd LD cycle for 3 cycles, then low_packet_valid=1 -> LD, FFS×3, LAF, LP, CPE, DA.
- soft_reset=3'b100 while in LD with dest_addr=1 -> no effect. soft_reset=3'b010 -> DA next cycle. reset asserted mid-LAF -> DA, detect_add=1, dest_addr=0.

Source files
------------

// File: rtl/router_fsm_nport.sv
// Ingress controller for the N-output router: header decode, payload/parity sequencing,
// FIFO-full stalls, soft resets, and packet drop on bad address or wait-for-empty timeout.
module router_fsm_nport #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 parity_done,
    input  logic                 low_packet_valid,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic                 drop_state,
    output logic [ADDR_W-1:0]    dest_addr,
    output logic                 addr_err,
    output logic                 timeout_err
);
    localparam int SPAN  = 2**ADDR_W;
    localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);
    localparam logic [ADDR_W:0]   PORT_LIM = (ADDR_W + 1)'(NUM_PORTS);

    typedef enum logic [3:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        CHECK_PARITY_ERROR,
        DROP_PACKET
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [SPAN-1:0]  empty_ext, sreset_ext;
    logic             addr_bad, timeout_hit;

    // Zero-extend per-port flags to the full address span so any address indexes safely.
    always_comb begin
        empty_ext                  = '0;
        sreset_ext                 = '0;
        empty_ext[NUM_PORTS-1:0]   = fifo_empty;
        sreset_ext[NUM_PORTS-1:0]  = soft_reset;
    end

    assign addr_bad    = {1'b0, data_in} >= PORT_LIM;
    assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) state <= DECODE_ADDRESS;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b0;
        drop_state    = 1'b0;
        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                if (pkt_valid) begin
                    if (addr_bad)                next_state = DROP_PACKET;
                    else if (empty_ext[data_in]) next_state = LOAD_FIRST_DATA;
                    else                         next_state = WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (empty_ext[dest_addr]) next_state = LOAD_FIRST_DATA;
                else if (timeout_hit)     next_state = DROP_PACKET;
            end
            LOAD_FIRST_DATA: begin
                lfd_state  = 1'b1;
                busy       = 1'b1;
                next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                if (fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = LOAD_PARITY;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
                next_state    = CHECK_PARITY_ERROR;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
                if (!fifo_full) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
                if (parity_done)           next_state = DECODE_ADDRESS;
                else if (low_packet_valid) next_state = LOAD_PARITY;
                else                       next_state = LOAD_DATA;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
                next_state  = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            DROP_PACKET: begin
                drop_state = 1'b1;
                if (!pkt_valid) next_state = DECODE_ADDRESS;
            end
            default: next_state = DECODE_ADDRESS;
        endcase
        // A read-timeout on the selected FIFO aborts the packet from any active state.
        if (state != DECODE_ADDRESS && state != DROP_PACKET && sreset_ext[dest_addr])
            next_state = DECODE_ADDRESS;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dest_addr   <= '0;
            wait_cnt    <= '0;
            addr_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state == DECODE_ADDRESS && pkt_valid) dest_addr <= data_in;
            if (state == WAIT_TILL_EMPTY) wait_cnt <= wait_cnt + CNT_W'(1);
            else                          wait_cnt <= '0;
            addr_err    <= (state == DECODE_ADDRESS)  && (next_state == DROP_PACKET);
            timeout_err <= (state == WAIT_TILL_EMPTY) && (next_state == DROP_PACKET);
        end
    end
endmodule

// File: tb/tb_router_fsm_nport.sv
// Bench for router_fsm_nport: directed vector table for the packet scenarios, then
// randomized traffic against a phase-level reference model.
module tb_router_fsm_nport;
    localparam int NP = 3;
    localparam int AW = 2;
    localparam int TO = 16;

    logic          clock;
    logic          reset, pkt_valid, parity_done, low_packet_valid, fifo_full;
    logic [AW-1:0] data_in;
    logic [NP-1:0] fifo_empty, soft_reset;
    logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic write_enb_reg, busy, drop_state, addr_err, timeout_err;
    logic [AW-1:0] dest_addr;

    router_fsm_nport #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .drop_state(drop_state),
        .dest_addr(dest_addr), .addr_err(addr_err), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum int {P_IDLE, P_WAIT, P_FIRST, P_BODY, P_PAR, P_FULL, P_AFTER, P_CHK, P_DROP} phase_t;

    typedef struct {
        logic          rst, pv;
        logic [AW-1:0] din;
        logic          pd, lpv, ff;
        logic [NP-1:0] fe, sr;
        phase_t        ph;
        logic [AW-1:0] ed;
        logic          eae, ete;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    phase_t        m_ph;
    logic [AW-1:0] m_dest;
    int            m_waited;
    logic          m_ae, m_te;

    // Expected {detect_add,lfd,ld,laf,full,rst_int,wen,busy,drop} for each phase.
    function automatic logic [8:0] decode(phase_t p);
        case (p)
            P_IDLE:  return 9'b100000000;
            P_WAIT:  return 9'b000000010;
            P_FIRST: return 9'b010000010;
            P_BODY:  return 9'b001000100;
            P_PAR:   return 9'b000000110;
            P_FULL:  return 9'b000010010;
            P_AFTER: return 9'b000100110;
            P_CHK:   return 9'b000001010;
            default: return 9'b000000001;
        endcase
    endfunction

    task automatic add(input logic rst, input logic pv, input int din, input logic pd,
                       input logic lpv, input logic ff, input int fe, input int sr,
                       input phase_t ph, input int ed, input logic eae, input logic ete);
        vec_t v;
        v.rst = rst; v.pv = pv; v.din = AW'(din); v.pd = pd; v.lpv = lpv; v.ff = ff;
        v.fe = NP'(fe); v.sr = NP'(sr); v.ph = ph; v.ed = AW'(ed); v.eae = eae; v.ete = ete;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input phase_t ph,
                         input logic [AW-1:0] ed, input logic eae, input logic ete);
        logic [12:0] act, exp;
        act = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, busy, drop_state, dest_addr, addr_err, timeout_err};
        exp = {decode(ph), ed, eae, ete};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b (dec,dest,ae,te)", nm, idx, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        phase_t nxt;
        logic   ae, te;
        if (reset) begin
            m_ph = P_IDLE; m_dest = '0; m_waited = 0; m_ae = 0; m_te = 0;
            return;
        end
        nxt = m_ph; ae = 0; te = 0;
        case (m_ph)
            P_IDLE: if (pkt_valid) begin
                if (int'(data_in) >= NP)    begin nxt = P_DROP; ae = 1; end
                else if (fifo_empty[data_in]) nxt = P_FIRST;
                else                          nxt = P_WAIT;
            end
            P_WAIT: if (fifo_empty[m_dest]) nxt = P_FIRST;
                    else if (TO != 0 && m_waited + 1 >= TO) begin nxt = P_DROP; te = 1; end
            P_FIRST: nxt = P_BODY;
            P_BODY:  if (fifo_full) nxt = P_FULL; else if (!pkt_valid) nxt = P_PAR;
            P_FULL:  if (!fifo_full) nxt = P_AFTER;
            P_AFTER: nxt = parity_done ? P_IDLE : (low_packet_valid ? P_PAR : P_BODY);
            P_PAR:   nxt = P_CHK;
            P_CHK:   nxt = fifo_full ? P_FULL : P_IDLE;
            default: if (!pkt_valid) nxt = P_IDLE;
        endcase
        if (m_ph != P_IDLE && m_ph != P_DROP && soft_reset[m_dest]) begin
            nxt = P_IDLE; te = 0;
        end
        if (m_ph == P_IDLE && pkt_valid) m_dest = data_in;
        m_waited = (m_ph == P_WAIT) ? m_waited + 1 : 0;
        m_ph = nxt; m_ae = ae; m_te = te;
    endtask

    int prob;

    initial begin
        reset = 1; pkt_valid = 0; data_in = '0; parity_done = 0; low_packet_valid = 0;
        fifo_full = 0; fifo_empty = '1; soft_reset = '0;

        // rst pv din pd lpv ff fe sr -> phase dest ae te
        add(1,0,0,0,0,0,7,0, P_IDLE,0,0,0);
        add(0,0,0,0,0,0,7,0, P_IDLE,0,0,0);
        // addr 1, three payload bytes, parity
        add(0,1,1,0,0,0,7,0, P_FIRST,1,0,0);
        add(0,1,1,0,0,0,7,0, P_BODY,1,0,0);
        add(0,1,1,0,0,0,7,0, P_BODY,1,0,0);
        add(0,1,1,0,0,0,7,0, P_BODY,1,0,0);
        add(0,0,1,0,0,0,7,0, P_PAR,1,0,0);
        add(0,0,1,0,0,0,7,0, P_CHK,1,0,0);
        add(0,0,1,0,0,0,7,0, P_IDLE,1,0,0);
        // addr 2 waits 5 cycles for its FIFO
        add(0,1,2,0,0,0,3,0, P_WAIT,2,0,0);
        for (int i = 0; i < 4; i++) add(0,1,2,0,0,0,3,0, P_WAIT,2,0,0);
        add(0,1,2,0,0,0,7,0, P_FIRST,2,0,0);
        add(0,0,2,0,0,0,7,0, P_BODY,2,0,0);
        add(0,0,2,0,0,0,7,0, P_PAR,2,0,0);
        add(0,0,2,0,0,0,7,0, P_CHK,2,0,0);
        add(0,0,2,0,0,0,7,0, P_IDLE,2,0,0);
        // addr 0 never empties: 16 WTE cycles, then drop with timeout pulse
        add(0,1,0,0,0,0,6,0, P_WAIT,0,0,0);
        for (int i = 0; i < TO - 1; i++) add(0,1,0,0,0,0,6,0, P_WAIT,0,0,0);
        add(0,1,0,0,0,0,6,0, P_DROP,0,0,1);
        add(0,1,0,0,0,0,6,0, P_DROP,0,0,0);
        add(0,0,0,1,0,0,6,0, P_IDLE,0,0,0);
        // FIFO empties on the watchdog's final cycle: load wins
        add(0,1,0,0,0,0,6,0, P_WAIT,0,0,0);
        for (int i = 0; i < TO - 1; i++) add(0,1,0,0,0,0,6,0, P_WAIT,0,0,0);
        add(0,1,0,0,0,0,7,0, P_FIRST,0,0,0);
        add(0,0,0,0,0,0,7,0, P_BODY,0,0,0);
        add(0,0,0,0,0,0,7,0, P_PAR,0,0,0);
        add(0,0,0,0,0,0,7,0, P_CHK,0,0,0);
        add(0,0,0,0,0,0,7,0, P_IDLE,0,0,0);
        // out-of-range address 3, bytes consumed, soft reset ignored in drop
        add(0,1,3,0,0,0,7,0, P_DROP,3,1,0);
        add(0,1,3,0,0,0,7,7, P_DROP,3,0,0);
        add(0,1,3,0,0,0,7,0, P_DROP,3,0,0);
        add(0,0,3,1,0,0,7,0, P_IDLE,3,0,0);
        // full stall of 3 cycles, then low_packet_valid
        add(0,1,1,0,0,0,7,0, P_FIRST,1,0,0);
        add(0,1,1,0,0,0,7,0, P_BODY,1,0,0);
        add(0,1,1,0,0,0,7,0, P_BODY,1,0,0);
        add(0,1,1,0,0,1,7,0, P_FULL,1,0,0);
        add(0,1,1,0,0,1,7,0, P_FULL,1,0,0);
        add(0,1,1,0,0,1,7,0, P_FULL,1,0,0);
        add(0,0,1,0,0,0,7,0, P_AFTER,1,0,0);
        add(0,0,1,0,1,0,7,0, P_PAR,1,0,0);
        add(0,0,1,0,0,0,7,0, P_CHK,1,0,0);
        add(0,0,1,0,0,0,7,0, P_IDLE,1,0,0);
        // LAF resumes payload, CPE re-stalls, LAF with parity_done ends
        add(0,1,2,0,0,0,7,0, P_FIRST,2,0,0);
        add(0,1,2,0,0,0,7,0, P_BODY,2,0,0);
        add(0,1,2,0,0,1,7,0, P_FULL,2,0,0);
        add(0,1,2,0,0,0,7,0, P_AFTER,2,0,0);
        add(0,1,2,0,0,0,7,0, P_BODY,2,0,0);
        add(0,0,2,0,0,0,7,0, P_PAR,2,0,0);
        add(0,0,2,0,0,1,7,0, P_CHK,2,0,0);
        add(0,0,2,0,0,1,7,0, P_FULL,2,0,0);
        add(0,0,2,0,0,0,7,0, P_AFTER,2,0,0);
        add(0,0,2,1,0,0,7,0, P_IDLE,2,0,0);
        // soft reset: other port ignored, selected port aborts; ignored in DA
        add(0,1,1,0,0,0,7,0, P_FIRST,1,0,0);
        add(0,1,1,0,0,0,7,0, P_BODY,1,0,0);
        add(0,1,1,0,0,0,7,4, P_BODY,1,0,0);
        add(0,1,1,0,0,0,7,2, P_IDLE,1,0,0);
        add(0,0,1,0,0,0,7,7, P_IDLE,1,0,0);
        // soft reset during WTE
        add(0,1,0,0,0,0,6,0, P_WAIT,0,0,0);
        add(0,1,0,0,0,0,6,1, P_IDLE,0,0,0);
        add(0,0,0,0,0,0,7,0, P_IDLE,0,0,0);
        // reset mid-LAF beats every other input
        add(0,1,2,0,0,0,7,0, P_FIRST,2,0,0);
        add(0,1,2,0,0,0,7,0, P_BODY,2,0,0);
        add(0,1,2,0,0,1,7,0, P_FULL,2,0,0);
        add(0,1,2,0,0,0,7,0, P_AFTER,2,0,0);
        add(1,1,3,1,1,1,0,7, P_IDLE,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; pkt_valid = vecs[i].pv; data_in = vecs[i].din;
            parity_done = vecs[i].pd; low_packet_valid = vecs[i].lpv;
            fifo_full = vecs[i].ff; fifo_empty = vecs[i].fe; soft_reset = vecs[i].sr;
            @(negedge clock);
            check("vec", i, vecs[i].ph, vecs[i].ed, vecs[i].eae, vecs[i].ete);
        end

        prob = 95;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       prob = 95;
                    1:       prob = 50;
                    default: prob = 3;
                endcase
            end
            reset            = (cyc == 0) || ($urandom_range(0, 199) == 0);
            pkt_valid        = ($urandom_range(0, 9) < 7);
            data_in          = AW'($urandom_range(0, 3));
            parity_done      = ($urandom_range(0, 4) == 0);
            low_packet_valid = ($urandom_range(0, 4) == 0);
            fifo_full        = ($urandom_range(0, 4) == 0);
            for (int b = 0; b < NP; b++) fifo_empty[b] = ($urandom_range(0, 99) < prob);
            soft_reset = ($urandom_range(0, 29) == 0) ? NP'(1 << $urandom_range(0, NP - 1)) : '0;
            model_step();
            @(negedge clock);
            check("rand", cyc, m_ph, m_dest, m_ae, m_te);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
